// File: rtl/host_io_pkg.sv
// host_io_pkg: command/state encodings and sizing helpers shared by the host I/O controller
package host_io_pkg;
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_START = 2'b10,
    CMD_ACK   = 2'b11
  } cmd_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic int nbytes(input int elem_w, input int data_w);
    return elem_w / data_w;
  endfunction
  function automatic int aw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/host_io_ctrl_if.sv
// host_io_ctrl_if: pad-side command/data pins plus core handshake; slave = controller, master = pads/core
interface host_io_ctrl_if import host_io_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int VEC_LEN  = 4,
  parameter int ELEM_W   = 8
);
  localparam int RW = aw(NUM_REGS);
  localparam int IW = aw(VEC_LEN);
  logic              en, write, load;
  logic [RW-1:0]     reg_select, core_rd_reg, core_wr_reg;
  logic [IW-1:0]     idx_select, core_rd_idx, core_wr_idx;
  logic [DATA_W-1:0] data_in, data_out;
  logic              core_start, core_done, core_wr_en;
  logic [ELEM_W-1:0] core_rd_data, core_wr_data;
  logic              interrupt_pin, read_led, write_led, load_led, matmul_led, en_led;
  modport slave (
    input  en, write, load, reg_select, idx_select, data_in, core_done,
           core_rd_reg, core_rd_idx, core_wr_en, core_wr_reg, core_wr_idx, core_wr_data,
    output data_out, core_start, core_rd_data, interrupt_pin,
           read_led, write_led, load_led, matmul_led, en_led
  );
  modport master (
    output en, write, load, reg_select, idx_select, data_in, core_done,
           core_rd_reg, core_rd_idx, core_wr_en, core_wr_reg, core_wr_idx, core_wr_data,
    input  data_out, core_start, core_rd_data, interrupt_pin,
           read_led, write_led, load_led, matmul_led, en_led
  );
endinterface

// File: rtl/host_io_regfile.sv
// host_io_regfile: NUM_REGS x VEC_LEN element store; byte-enable write, core element read, host byte read
module host_io_regfile import host_io_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int VEC_LEN  = 4,
  parameter int ELEM_W   = 8,
  localparam int BYTES   = nbytes(ELEM_W, DATA_W),
  localparam int RW      = aw(NUM_REGS),
  localparam int IW      = aw(VEC_LEN),
  localparam int PW      = aw(BYTES)
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              i_we,
  input  logic [RW-1:0]     i_wreg,
  input  logic [IW-1:0]     i_widx,
  input  logic [BYTES-1:0]  i_be,
  input  logic [ELEM_W-1:0] i_wdata,
  input  logic [RW-1:0]     i_crd_reg,
  input  logic [IW-1:0]     i_crd_idx,
  output logic [ELEM_W-1:0] o_crd_data,
  input  logic [RW-1:0]     i_hrd_reg,
  input  logic [IW-1:0]     i_hrd_idx,
  input  logic [PW-1:0]     i_hrd_byte,
  output logic [DATA_W-1:0] o_hrd_byte
);
  logic [ELEM_W-1:0] r_mem [NUM_REGS][VEC_LEN];
  logic [ELEM_W-1:0] w_host_elem;
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) r_mem <= '{default: '0};
    else if (i_we)
      for (int b = 0; b < BYTES; b++)
        if (i_be[b]) r_mem[i_wreg][i_widx][b*DATA_W +: DATA_W] <= i_wdata[b*DATA_W +: DATA_W];
  assign o_crd_data  = r_mem[i_crd_reg][i_crd_idx];
  assign w_host_elem = r_mem[i_hrd_reg][i_hrd_idx];
  assign o_hrd_byte  = w_host_elem[i_hrd_byte*DATA_W +: DATA_W];
endmodule

// File: rtl/host_io_ctrl.sv
// host_io_ctrl: edge-triggered AUX command decoder, run/done FSM, byte pointers and LEDs over host_io_regfile (ports: clk, clear_n, bus slave)
module host_io_ctrl import host_io_pkg::*; #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int VEC_LEN  = 4,
  parameter int ELEM_W   = 8
) (
  input logic           clk,
  input logic           clear_n,
  host_io_ctrl_if.slave bus
);
  localparam int BYTES = nbytes(ELEM_W, DATA_W);
  localparam int RW    = aw(NUM_REGS);
  localparam int IW    = aw(VEC_LEN);
  localparam int PW    = aw(BYTES);
  cmd_t              w_cmd, r_prev_cmd;
  state_t            r_state;
  logic [RW+IW-1:0]  w_addr, r_prev_addr;
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, w_wr_ptr, w_rd_ptr;
  logic              w_fire, w_addr_chg, w_host_we, w_start, w_ack, w_done, w_core_we, w_irq_clr;
  logic [RW-1:0]     w_wreg;
  logic [IW-1:0]     w_widx;
  logic [BYTES-1:0]  w_be;
  logic [ELEM_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_host_byte, r_data_out;
  logic              r_core_start, r_irq, r_read_led, r_write_led, r_load_led, r_matmul;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(BYTES - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_cmd      = cmd_t'({bus.load, bus.write});
  assign w_fire     = bus.en && w_cmd != CMD_IDLE && r_prev_cmd == CMD_IDLE;
  assign w_addr     = {bus.reg_select, bus.idx_select};
  assign w_addr_chg = bus.en && w_addr != r_prev_addr;
  // a fresh address restarts both byte sequences in the same cycle it appears
  assign w_wr_ptr   = w_addr_chg ? '0 : r_wr_ptr;
  assign w_rd_ptr   = w_addr_chg ? '0 : r_rd_ptr;
  assign w_host_we  = w_fire && w_cmd == CMD_WRITE && r_state != ST_RUN;
  assign w_start    = w_fire && w_cmd == CMD_START && r_state != ST_RUN;
  assign w_ack      = w_fire && w_cmd == CMD_ACK;
  assign w_done     = bus.en && bus.core_done && r_state == ST_RUN;
  assign w_core_we  = bus.en && bus.core_wr_en && r_state == ST_RUN;
  assign w_irq_clr  = (w_start || w_ack) && r_state == ST_DONE;
  // host writes are blocked in RUN, so the single write port is shared without conflict
  assign w_wreg     = w_core_we ? bus.core_wr_reg : bus.reg_select;
  assign w_widx     = w_core_we ? bus.core_wr_idx : bus.idx_select;
  assign w_be       = w_core_we ? '1 : BYTES'(1) << w_wr_ptr;
  assign w_wdata    = w_core_we ? bus.core_wr_data : {BYTES{bus.data_in}};
  host_io_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .VEC_LEN(VEC_LEN), .ELEM_W(ELEM_W)) u_rf (
    .clk        (clk),
    .clear_n    (clear_n),
    .i_we       (w_host_we || w_core_we),
    .i_wreg     (w_wreg),
    .i_widx     (w_widx),
    .i_be       (w_be),
    .i_wdata    (w_wdata),
    .i_crd_reg  (bus.core_rd_reg),
    .i_crd_idx  (bus.core_rd_idx),
    .o_crd_data (bus.core_rd_data),
    .i_hrd_reg  (bus.reg_select),
    .i_hrd_idx  (bus.idx_select),
    .i_hrd_byte (w_rd_ptr),
    .o_hrd_byte (w_host_byte)
  );
  always_ff @(posedge clk or negedge clear_n)
    if (!clear_n) begin
      r_prev_cmd   <= CMD_IDLE;
      r_prev_addr  <= '0;
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_data_out   <= '0;
      r_core_start <= 1'b0;
      r_irq        <= 1'b0;
      r_read_led   <= 1'b0;
      r_write_led  <= 1'b0;
      r_load_led   <= 1'b0;
      r_matmul     <= 1'b0;
    end else begin
      r_prev_cmd   <= w_cmd;
      r_prev_addr  <= bus.en ? w_addr : r_prev_addr;
      r_state      <= w_start ? ST_RUN : w_done ? ST_DONE : (w_ack && r_state == ST_DONE) ? ST_IDLE : r_state;
      r_matmul     <= w_start || (r_state == ST_RUN && !w_done);
      r_wr_ptr     <= w_host_we ? inc(w_wr_ptr) : w_wr_ptr;
      r_rd_ptr     <= (w_ack && r_state != ST_DONE) ? inc(w_rd_ptr) : w_rd_ptr;
      r_data_out   <= w_host_byte;
      r_core_start <= w_start;
      r_irq        <= w_done ? 1'b1 : w_irq_clr ? 1'b0 : r_irq;
      r_read_led   <= w_cmd == CMD_IDLE && r_state != ST_RUN;
      r_write_led  <= w_host_we;
      r_load_led   <= w_start;
    end
  assign bus.data_out      = r_data_out;
  assign bus.core_start    = r_core_start;
  assign bus.interrupt_pin = r_irq;
  assign bus.read_led      = r_read_led;
  assign bus.write_led     = r_write_led;
  assign bus.load_led      = r_load_led;
  assign bus.matmul_led    = r_matmul;
  assign bus.en_led        = bus.en & clear_n;
endmodule

// File: tb/tb_host_io_ctrl.sv
// tb_host_io_ctrl: directed self-checking bench for host_io_ctrl with 16-bit elements over an 8-bit pad bus
module tb_host_io_ctrl;
  logic clk = 1'b0;
  logic clear_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  host_io_ctrl_if #(.DATA_W(8), .NUM_REGS(8), .VEC_LEN(4), .ELEM_W(16)) bus ();
  host_io_ctrl #(.DATA_W(8), .NUM_REGS(8), .VEC_LEN(4), .ELEM_W(16)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );
  always #5 clk = ~clk;
  logic [30:0] outs;
  assign outs = {bus.data_out, bus.core_start, bus.interrupt_pin, bus.read_led, bus.write_led,
                 bus.load_led, bus.matmul_led, bus.en_led, bus.core_rd_data};
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_cmd(input logic [1:0] c);
    {bus.load, bus.write} = c;
  endtask
  task automatic host_write(input logic [2:0] r, input logic [1:0] i, input logic [7:0] d);
    bus.reg_select = r;
    bus.idx_select = i;
    bus.data_in = d;
    set_cmd(2'b01);
    step();
    set_cmd(2'b00);
    step();
  endtask
  task automatic core_rd(input logic [2:0] r, input logic [1:0] i);
    bus.core_rd_reg = r;
    bus.core_rd_idx = i;
    #1;
  endtask
  task automatic test_reset();
    bus.en = 1'b1; set_cmd(2'b00); bus.reg_select = '0; bus.idx_select = '0; bus.data_in = '0;
    bus.core_done = 1'b0; bus.core_rd_reg = '0; bus.core_rd_idx = '0;
    bus.core_wr_en = 1'b0; bus.core_wr_reg = '0; bus.core_wr_idx = '0; bus.core_wr_data = '0;
    clear_n = 1'b0;
    step(2);
    n_checks++; if (outs !== 31'h0) begin n_fail++; $display("FAIL reset_outs: got %h expected 0", outs); end
    clear_n = 1'b1;
    step();
    n_checks++; if (bus.read_led !== 1'b1) begin n_fail++; $display("FAIL reset_read_led: got %b expected 1", bus.read_led); end
    n_checks++; if (bus.en_led !== 1'b1) begin n_fail++; $display("FAIL reset_en_led: got %b expected 1", bus.en_led); end
  endtask
  task automatic test_write_read();
    core_rd(3'd1, 2'd2);
    bus.reg_select = 3'd1; bus.idx_select = 2'd2; bus.data_in = 8'h02;
    set_cmd(2'b01);
    step();
    n_checks++; if (bus.write_led !== 1'b1) begin n_fail++; $display("FAIL wr_led_on: got %b expected 1", bus.write_led); end
    n_checks++; if (bus.core_rd_data !== 16'h0002) begin n_fail++; $display("FAIL wr_core_rd: got %h expected 0002", bus.core_rd_data); end
    set_cmd(2'b00);
    step();
    n_checks++; if (bus.data_out !== 8'h02) begin n_fail++; $display("FAIL wr_data_out: got %h expected 02", bus.data_out); end
    n_checks++; if (bus.write_led !== 1'b0) begin n_fail++; $display("FAIL wr_led_off: got %b expected 0", bus.write_led); end
  endtask
  task automatic test_byte_serial();
    core_rd(3'd0, 2'd0);
    host_write(3'd0, 2'd0, 8'h34);
    host_write(3'd0, 2'd0, 8'hCD);
    n_checks++; if (bus.core_rd_data !== 16'hCD34) begin n_fail++; $display("FAIL bs_elem: got %h expected CD34", bus.core_rd_data); end
    n_checks++; if (bus.data_out !== 8'h34) begin n_fail++; $display("FAIL bs_byte0: got %h expected 34", bus.data_out); end
    set_cmd(2'b11); step(); set_cmd(2'b00); step();
    n_checks++; if (bus.data_out !== 8'hCD) begin n_fail++; $display("FAIL bs_ack1: got %h expected CD", bus.data_out); end
    set_cmd(2'b11); step(); set_cmd(2'b00); step();
    n_checks++; if (bus.data_out !== 8'h34) begin n_fail++; $display("FAIL bs_ack_wrap: got %h expected 34", bus.data_out); end
    host_write(3'd0, 2'd0, 8'h56);
    n_checks++; if (bus.core_rd_data !== 16'hCD56) begin n_fail++; $display("FAIL bs_wr_wrap: got %h expected CD56", bus.core_rd_data); end
  endtask
  task automatic test_hold();
    int highs;
    core_rd(3'd2, 2'd1);
    bus.reg_select = 3'd2; bus.idx_select = 2'd1; bus.data_in = 8'hAA;
    set_cmd(2'b01);
    step();
    n_checks++; if (bus.write_led !== 1'b1) begin n_fail++; $display("FAIL hold_led_first: got %b expected 1", bus.write_led); end
    bus.data_in = 8'hBB;
    highs = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      highs += int'(bus.write_led);
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL hold_led_once: got %0d extra high cycles expected 0", highs); end
    set_cmd(2'b00);
    step();
    n_checks++; if (bus.core_rd_data !== 16'h00AA) begin n_fail++; $display("FAIL hold_one_byte: got %h expected 00AA", bus.core_rd_data); end
    bus.idx_select = 2'd0; step();
    bus.idx_select = 2'd1; step();
    host_write(3'd2, 2'd1, 8'h11);
    n_checks++; if (bus.core_rd_data !== 16'h0011) begin n_fail++; $display("FAIL hold_ptr_reset: got %h expected 0011", bus.core_rd_data); end
  endtask
  task automatic test_run();
    core_rd(3'd0, 2'd0);
    set_cmd(2'b10);
    step();
    n_checks++; if (bus.core_start !== 1'b1) begin n_fail++; $display("FAIL run_start: got %b expected 1", bus.core_start); end
    n_checks++; if (bus.matmul_led !== 1'b1) begin n_fail++; $display("FAIL run_matmul: got %b expected 1", bus.matmul_led); end
    n_checks++; if (bus.load_led !== 1'b1) begin n_fail++; $display("FAIL run_load_led: got %b expected 1", bus.load_led); end
    step();
    n_checks++; if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL run_start_once: got %b expected 0", bus.core_start); end
    n_checks++; if (bus.load_led !== 1'b0) begin n_fail++; $display("FAIL run_load_led_off: got %b expected 0", bus.load_led); end
    set_cmd(2'b00); step();
    set_cmd(2'b10); step();
    n_checks++; if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL run_restart_ignored: got %b expected 0", bus.core_start); end
    set_cmd(2'b00); step();
    host_write(3'd0, 2'd0, 8'hEE);
    n_checks++; if (bus.core_rd_data !== 16'hCD56) begin n_fail++; $display("FAIL run_host_wr_ignored: got %h expected CD56", bus.core_rd_data); end
    bus.core_wr_en = 1'b1; bus.core_wr_reg = 3'd7; bus.core_wr_idx = 2'd3; bus.core_wr_data = 16'h001F;
    step();
    bus.core_wr_en = 1'b0;
    core_rd(3'd7, 2'd3);
    n_checks++; if (bus.core_rd_data !== 16'h001F) begin n_fail++; $display("FAIL run_core_wr: got %h expected 001F", bus.core_rd_data); end
    n_checks++; if (bus.matmul_led !== 1'b1) begin n_fail++; $display("FAIL run_still: got %b expected 1", bus.matmul_led); end
    bus.core_done = 1'b1; step(); bus.core_done = 1'b0;
    n_checks++; if (bus.interrupt_pin !== 1'b1) begin n_fail++; $display("FAIL run_irq_set: got %b expected 1", bus.interrupt_pin); end
    n_checks++; if (bus.matmul_led !== 1'b0) begin n_fail++; $display("FAIL run_done_led: got %b expected 0", bus.matmul_led); end
    step();
    set_cmd(2'b11); step();
    n_checks++; if (bus.interrupt_pin !== 1'b0) begin n_fail++; $display("FAIL run_irq_ack: got %b expected 0", bus.interrupt_pin); end
    set_cmd(2'b00); step();
    n_checks++; if (bus.data_out !== 8'h56) begin n_fail++; $display("FAIL run_ack_no_adv: got %h expected 56", bus.data_out); end
    set_cmd(2'b11); step(); set_cmd(2'b00); step();
    n_checks++; if (bus.data_out !== 8'hCD) begin n_fail++; $display("FAIL run_idle_after_ack: got %h expected CD", bus.data_out); end
  endtask
  task automatic test_enable();
    core_rd(3'd3, 2'd0);
    bus.en = 1'b0;
    #1;
    n_checks++; if (bus.en_led !== 1'b0) begin n_fail++; $display("FAIL en_led_low: got %b expected 0", bus.en_led); end
    bus.reg_select = 3'd3; bus.idx_select = 2'd0; bus.data_in = 8'h77;
    set_cmd(2'b01); step();
    n_checks++; if (bus.write_led !== 1'b0) begin n_fail++; $display("FAIL en_wr_led: got %b expected 0", bus.write_led); end
    set_cmd(2'b00); step();
    n_checks++; if (bus.core_rd_data !== 16'h0000) begin n_fail++; $display("FAIL en_wr_blocked: got %h expected 0000", bus.core_rd_data); end
    set_cmd(2'b10); step();
    n_checks++; if (bus.core_start !== 1'b0) begin n_fail++; $display("FAIL en_start_blocked: got %b expected 0", bus.core_start); end
    set_cmd(2'b00); step();
    n_checks++; if (bus.matmul_led !== 1'b0) begin n_fail++; $display("FAIL en_no_run: got %b expected 0", bus.matmul_led); end
    bus.en = 1'b1; step();
    n_checks++; if (bus.en_led !== 1'b1) begin n_fail++; $display("FAIL en_led_high: got %b expected 1", bus.en_led); end
  endtask
  task automatic test_reset_mid_run();
    set_cmd(2'b10); step(); set_cmd(2'b00); step();
    bus.core_done = 1'b1; step(); bus.core_done = 1'b0;
    n_checks++; if (bus.interrupt_pin !== 1'b1) begin n_fail++; $display("FAIL mr_irq_set: got %b expected 1", bus.interrupt_pin); end
    set_cmd(2'b10); step();
    n_checks++; if (bus.interrupt_pin !== 1'b0) begin n_fail++; $display("FAIL mr_restart_clr_irq: got %b expected 0", bus.interrupt_pin); end
    n_checks++; if (bus.core_start !== 1'b1) begin n_fail++; $display("FAIL mr_restart_start: got %b expected 1", bus.core_start); end
    set_cmd(2'b00); step();
    clear_n = 1'b0;
    #1;
    n_checks++; if (outs !== 31'h0) begin n_fail++; $display("FAIL mr_reset_outs: got %h expected 0", outs); end
    step();
    clear_n = 1'b1;
    step();
    bus.core_done = 1'b1; step(); bus.core_done = 1'b0; step();
    n_checks++; if (bus.interrupt_pin !== 1'b0) begin n_fail++; $display("FAIL mr_done_ignored: got %b expected 0", bus.interrupt_pin); end
    n_checks++; if (bus.matmul_led !== 1'b0) begin n_fail++; $display("FAIL mr_idle: got %b expected 0", bus.matmul_led); end
    bus.core_wr_en = 1'b1; bus.core_wr_reg = 3'd4; bus.core_wr_idx = 2'd0; bus.core_wr_data = 16'hBEEF;
    step();
    bus.core_wr_en = 1'b0;
    core_rd(3'd4, 2'd0);
    n_checks++; if (bus.core_rd_data !== 16'h0000) begin n_fail++; $display("FAIL mr_core_wr_ignored: got %h expected 0000", bus.core_rd_data); end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_serial();
    test_hold();
    test_run();
    test_enable();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/host_io_ctrl.md
# host_io_ctrl

Parametrised host-side I/O controller for the matrix-multiply chip. It replaces the fixed 8-bit, 8×4 AUX/data_in front end with configurable register count, vector length and element width; elements wider than the pin bus are transferred byte-serially. It owns the operand/result register file and the start/done handshake to the matmul core. It also drives the interrupt pin and the status LEDs. It sits between the chip pads and the matmul core.

## Interface
Parameters:
- DATA_W, 8, pad data bus width.
- NUM_REGS, 8, number of vector registers.
- VEC_LEN, 4, elements per register.
- ELEM_W, 8, element width; must be a multiple of DATA_W. BYTES = ELEM_W/DATA_W.

Ports:
- clk  in  1  clock.
- clear_n  in  1  reset; one clock, asynchronous, active-low.
- en  in  1  global enable.
- write  in  1  AUX command bit 0.
- load  in  1  AUX command bit 1.
- reg_select  in  clog2(NUM_REGS)  register address.
- idx_select  in  clog2(VEC_LEN)  element address.
- data_in  in  DATA_W  host write byte.
- data_out  out  DATA_W  host read byte, registered.
- core_start  out  1  one-cycle start pulse to the core.
- core_done  in  1  one-cycle completion pulse from the core.
- core_rd_reg, core_rd_idx  in  address widths  core operand read address.
- core_rd_data  out  ELEM_W  combinational operand read data.
- core_wr_en  in  1  core result write enable.
- core_wr_reg, core_wr_idx  in  address widths  core result write address.
- core_wr_data  in  ELEM_W  core result write data.
- interrupt_pin  out  1  sticky completion interrupt.
- read_led, write_led, load_led, matmul_led, en_led  out  1 each  status LEDs.

## Operation
- Command encoding cmd = {load, write}:
  - 00: IDLE/READ.
  - 01: WRITE_BYTE.
  - 10: START.
  - 11: ACK_ADVANCE.
- Commands are edge-triggered. A command fires in the cycle where cmd ≠ 00 and the registered previous cmd = 00. Holding a command never repeats it. Changing directly from one non-zero cmd to another does not fire.
- While en = 0, no command fires. State, the register file and the pointers all hold.
- WRITE_BYTE, accepted only in IDLE or DONE:
  - Writes data_in into byte wr_ptr of element [reg_select][idx_select], LSB byte first.
  - wr_ptr then increments, wrapping at BYTES.
- Byte pointers:
  - wr_ptr and rd_ptr both reset to 0 whenever {reg_select, idx_select} differs from its registered previous value.
- START:
  - In IDLE or DONE: pulses core_start for one cycle and enters RUN. Starting from DONE also clears the interrupt.
  - In RUN: ignored.
- States:
  - IDLE → RUN on START.
  - RUN → DONE on core_done; interrupt_pin is set the same edge.
  - DONE → IDLE on ACK_ADVANCE, which clears interrupt_pin.
  - DONE → RUN on START.
- ACK_ADVANCE outside DONE increments rd_ptr, wrapping at BYTES. In DONE it acknowledges only; rd_ptr is unchanged.
- data_out is registered each cycle as byte rd_ptr of element [reg_select][idx_select]. Byte rd_ptr is selected by the rd_ptr value present in that cycle.
- Core writes (core_wr_en) take effect only in RUN; they are ignored otherwise. Host writes are ignored in RUN, so the write port never conflicts.
- A core_done arriving outside RUN is ignored.
- LEDs:
  - en_led = en, combinational.
  - matmul_led = (state == RUN).
  - read_led = registered (cmd == 00 && state != RUN).
  - write_led and load_led are high for exactly one cycle after an accepted WRITE_BYTE or START.

## Timing
- Reset asserted: all outputs 0, register file zeroed, state IDLE, pointers 0, previous-cmd register 00.
- Command edge in cycle N: its effect (register write, core_start, state change) is visible after the edge ending cycle N.
- Reading back: data_out reflects a write, or an address change, one cycle after the write takes effect.
- core_start is high exactly one cycle, the cycle after the START edge.
- core_done to interrupt_pin: 1 cycle.
- Reset mid-RUN aborts to IDLE and clears the interrupt. The core must be reset alongside.

## Structure
- Package host_io_pkg holds:
  - cmd_t enum: CMD_IDLE, CMD_WRITE, CMD_START, CMD_ACK.
  - state_t enum: ST_IDLE, ST_RUN, ST_DONE.
  - The BYTES and address-width functions.
- Sub-module host_io_regfile: NUM_REGS×VEC_LEN×ELEM_W storage with:
  - a byte-enable write port;
  - one combinational element read port for the core;
  - one byte-select read port for the host.
- host_io_ctrl contains the command decoder, FSM, pointers and LEDs.

## Test plan
- Defaults. Write 0x02 to [1][2] (cmd 00→01→00), then read with cmd 00 → data_out = 0x02 two cycles after the write edge; core_rd_data at [1][2] = 0x02.
- ELEM_W=16. Write 0x34 then 0xCD to [0][0] → core_rd_data = 0xCD34. Two ACK_ADVANCE commands with data_out sampled after each → 0x34, 0xCD, 0x34 (wraps).
- Hold write=1 for 5 cycles → exactly one byte written and write_led high for one cycle. Toggle idx_select → wr_ptr returns to 0.
- START → core_start pulses once and matmul_led = 1. A second START and a WRITE during RUN are ignored (register contents unchanged). A core write of 0x1F to [7][3] is stored. core_done → interrupt_pin = 1 next cycle; ACK → interrupt_pin = 0 and state IDLE.
- en=0 with WRITE and START edges → no change; en_led = 0.
- Assert clear_n low mid-RUN → all outputs 0 immediately. After release, core_done is ignored and interrupt_pin stays 0.
